// File: rtl/hwpe_stream_package.sv
// Shared HWPE-Stream types and helpers: serializer FSM state and a
// "next set bit above index" search reused by chunk-sequencing controllers.
package hwpe_stream_package;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } hwpe_stream_serialize_state_t;

    // Upper bound on chunks per word handled by the mask helpers.
    localparam int HWPE_STREAM_MAX_CHUNKS = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } hwpe_stream_next_set_t;

    // Lowest set bit of mask strictly above 'from'; from = -1 searches the whole mask.
    function automatic hwpe_stream_next_set_t hwpe_stream_next_set(
        input logic [HWPE_STREAM_MAX_CHUNKS-1:0] mask,
        input int                                from
    );
        hwpe_stream_next_set_t res;
        res = '0;
        // Scan downwards so the last hit kept is the lowest qualifying index.
        for (int i = HWPE_STREAM_MAX_CHUNKS - 1; i >= 0; i--) begin
            if (mask[i] && (i > from)) begin
                res.found = 1'b1;
                res.idx   = i[4:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hwpe_stream_serialize.sv
// Wide-to-narrow HWPE-Stream serializer: captures one DATA_WIDTH_IN word and
// emits it as NB_CHUNKS narrow chunks, LSB chunk first, optionally skipping
// chunks whose byte strobes are all zero. Pop side is driven from registers only.
module hwpe_stream_serialize
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_CHUNKS     = 2,
    parameter int unsigned DATA_WIDTH_IN = 128,
    parameter bit          SKIP_EMPTY    = 1'b0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    // wide sink
    input  logic                                  push_valid_i,
    output logic                                  push_ready_o,
    input  logic [DATA_WIDTH_IN-1:0]              push_data_i,
    input  logic [DATA_WIDTH_IN/8-1:0]            push_strb_i,
    // narrow source
    output logic                                  pop_valid_o,
    input  logic                                  pop_ready_i,
    output logic [DATA_WIDTH_IN/NB_CHUNKS-1:0]    pop_data_o,
    output logic [DATA_WIDTH_IN/NB_CHUNKS/8-1:0]  pop_strb_o,
    output logic                                  pop_last_o,
    output logic                                  busy_o
);

    localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN / NB_CHUNKS;
    localparam int unsigned STRB_IN        = DATA_WIDTH_IN / 8;
    localparam int unsigned STRB_OUT       = DATA_WIDTH_OUT / 8;
    localparam int unsigned IDX_W          = $clog2(NB_CHUNKS);

    hwpe_stream_serialize_state_t r_state;
    logic [IDX_W-1:0]             r_idx;
    logic [DATA_WIDTH_IN-1:0]     r_buf_data;
    logic [STRB_IN-1:0]           r_buf_strb;

    logic [HWPE_STREAM_MAX_CHUNKS-1:0] w_pend_in;
    logic [HWPE_STREAM_MAX_CHUNKS-1:0] w_pend_buf;
    hwpe_stream_next_set_t             w_first;
    hwpe_stream_next_set_t             w_next;
    logic                              w_push_hs;
    logic                              w_pop_hs;
    logic                              w_unused_idx_bits;

    // Pending-chunk masks for the incoming word and for the held word.
    // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
    always_comb begin
        w_pend_in  = '0;
        w_pend_buf = '0;
        for (int k = 0; k < int'(NB_CHUNKS); k++) begin
            w_pend_in[k]  = SKIP_EMPTY ? (|push_strb_i[k*STRB_OUT +: STRB_OUT]) : 1'b1;
            w_pend_buf[k] = SKIP_EMPTY ? (|r_buf_strb[k*STRB_OUT +: STRB_OUT])  : 1'b1;
        end
    end

    assign w_first = hwpe_stream_next_set(w_pend_in, -1);
    assign w_next  = hwpe_stream_next_set(w_pend_buf, int'(r_idx));

    // Search results are 5 bits wide; only the low IDX_W bits address a chunk.
    assign w_unused_idx_bits = ^{w_first.idx, w_next.idx};

    // Chunk mux: select slice r_idx of the held word.
    always_comb begin
        pop_data_o = '0;
        pop_strb_o = '0;
        for (int k = 0; k < int'(NB_CHUNKS); k++) begin
            if (r_idx == IDX_W'(k)) begin
                pop_data_o = r_buf_data[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
                pop_strb_o = r_buf_strb[k*STRB_OUT +: STRB_OUT];
            end
        end
    end

    assign pop_valid_o = (r_state == SEND);
    assign pop_last_o  = (r_state == SEND) && !w_next.found;
    assign busy_o      = (r_state == SEND);

    // Accept in IDLE, or while the last chunk leaves, so words stream without bubbles.
    assign push_ready_o = !rst_i && !clear_i &&
                          ((r_state == IDLE) || (pop_ready_i && pop_last_o));
    assign w_push_hs    = push_valid_i && push_ready_o;
    assign w_pop_hs     = pop_valid_o && pop_ready_i;

    // FSM, chunk counter and word buffer; reset/clear override any handshake.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_buf_data <= '0;
            r_buf_strb <= '0;
        end else if (w_push_hs) begin
            r_buf_data <= push_data_i;
            r_buf_strb <= push_strb_i;
            if (w_first.found) begin
                r_state <= SEND;
                r_idx   <= w_first.idx[IDX_W-1:0];
            end else begin
                // All-empty word under SKIP_EMPTY: consumed and dropped.
                r_state <= IDLE;
            end
        end else if (w_pop_hs) begin
            if (pop_last_o) begin
                r_state <= IDLE;
            end else begin
                r_idx <= w_next.idx[IDX_W-1:0];
            end
        end
    end

endmodule
